// File: rtl/iiitb_fifo_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode encodings, a clog2 helper and the
// parameter legality check evaluated at elaboration time.
package iiitb_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit params_legal(input int unsigned depth,
                                        input int unsigned af_thresh,
                                        input int unsigned ae_thresh,
                                        input int unsigned mode);
        return (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 1) &&
               ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/iiitb_fifo_mem.sv
// DEPTH x DATA_WIDTH storage array: synchronous write port, asynchronous read port.
// Contents are intentionally never reset.
module iiitb_fifo_mem
    import iiitb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/iiitb_param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable registered or first-word-fall-through read.
module iiitb_param_fifo
    import iiitb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = FIFO_MODE_STD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_Enable,
    input  logic [DATA_WIDTH-1:0] buffer_Input,
    input  logic                  read_Enable,
    output logic [DATA_WIDTH-1:0] buffer_Output,
    output logic                  read_Valid,
    output logic                  sig_Full,
    output logic                  sig_Empty,
    output logic                  sig_Almost_Full,
    output logic                  sig_Almost_Empty,
    output logic [ADDR_WIDTH:0]   fill_Count,
    input  logic                  clear_Errors,
    output logic                  sig_Overflow,
    output logic                  sig_Underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_check
        $fatal(1, "iiitb_param_fifo: threshold or read-mode parameter out of range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  full, empty;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    // Count is one bit wider than the pointers so a full FIFO is distinguishable from empty.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = write_Enable && !full;
    assign pop_ok  = read_Enable && !empty;

    assign sig_Full         = full;
    assign sig_Empty        = empty;
    assign sig_Almost_Full  = (32'(count_q) >= AF_THRESH);
    assign sig_Almost_Empty = (32'(count_q) <= AE_THRESH);
    assign fill_Count       = count_q;
    assign sig_Overflow     = ovf_q;
    assign sig_Underflow    = unf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A rejected request in the same cycle as clear_Errors leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_Errors) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (write_Enable && full) begin
            ovf_d = 1'b1;
        end
        if (read_Enable && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    iiitb_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk_i    (clock),
        .wr_en_i  (push_ok),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(buffer_Input),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign buffer_Output = rd_data;
        assign read_Valid    = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  rvalid_q, rvalid_d;

        always_comb begin
            dout_d   = dout_q;
            rvalid_d = pop_ok;
            if (pop_ok) begin
                dout_d = rd_data;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                dout_q   <= dout_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign buffer_Output = dout_q;
        assign read_Valid    = rvalid_q;
    end

endmodule

// File: tb/tb_iiitb_param_fifo.sv
// Bench for iiitb_param_fifo: three instances (default STD, default FWFT, 16x32 STD) share one
// stimulus stream and are checked every cycle against a queue model plus literal expectations.
module tb_iiitb_param_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic        clr   = 1'b0;
    logic [15:0] din   = '0;
    bit          done  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  d0_out, d1_out;
    logic [15:0] d2_out;
    logic [3:0]  d0_cnt, d1_cnt;
    logic [5:0]  d2_cnt;
    logic d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic d1_rv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
    logic d2_rv, d2_full, d2_empty, d2_af, d2_ae, d2_ovf, d2_unf;

    always #5 clock = ~clock;

    iiitb_param_fifo dut0 (
        .clock(clock), .reset(reset), .write_Enable(we), .buffer_Input(din[7:0]),
        .read_Enable(re), .buffer_Output(d0_out), .read_Valid(d0_rv), .sig_Full(d0_full),
        .sig_Empty(d0_empty), .sig_Almost_Full(d0_af), .sig_Almost_Empty(d0_ae),
        .fill_Count(d0_cnt), .clear_Errors(clr), .sig_Overflow(d0_ovf), .sig_Underflow(d0_unf)
    );

    iiitb_param_fifo #(.FWFT(1)) dut1 (
        .clock(clock), .reset(reset), .write_Enable(we), .buffer_Input(din[7:0]),
        .read_Enable(re), .buffer_Output(d1_out), .read_Valid(d1_rv), .sig_Full(d1_full),
        .sig_Empty(d1_empty), .sig_Almost_Full(d1_af), .sig_Almost_Empty(d1_ae),
        .fill_Count(d1_cnt), .clear_Errors(clr), .sig_Overflow(d1_ovf), .sig_Underflow(d1_unf)
    );

    iiitb_param_fifo #(
        .DATA_WIDTH(16), .ADDR_WIDTH(5), .AF_THRESH(30), .AE_THRESH(1), .FWFT(0)
    ) dut2 (
        .clock(clock), .reset(reset), .write_Enable(we), .buffer_Input(din),
        .read_Enable(re), .buffer_Output(d2_out), .read_Valid(d2_rv), .sig_Full(d2_full),
        .sig_Empty(d2_empty), .sig_Almost_Full(d2_af), .sig_Almost_Empty(d2_ae),
        .fill_Count(d2_cnt), .clear_Errors(clr), .sig_Overflow(d2_ovf), .sig_Underflow(d2_unf)
    );

    // Behavioural model: one queue per instance holding the words in FIFO order.
    logic [15:0] mq [3][$];
    int unsigned dep  [3] = '{8, 8, 32};
    int unsigned afth [3] = '{6, 6, 30};
    int unsigned aeth [3] = '{2, 2, 1};
    bit          fw   [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] msk  [3] = '{16'h00ff, 16'h00ff, 16'hffff};
    bit          m_ovf[3];
    bit          m_unf[3];
    bit          m_val[3];
    logic [15:0] m_out[3];

    initial begin
        int  sz;
        bit  pu, po;
        for (int i = 0; i < 3; i++) begin
            m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_val[i] = 1'b0; m_out[i] = '0;
        end
        forever begin
            @(posedge clock or negedge reset);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    mq[i].delete();
                    m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_val[i] = 1'b0; m_out[i] = '0;
                end else begin
                    sz = mq[i].size();
                    pu = we && (sz < int'(dep[i]));
                    po = re && (sz > 0);
                    if (we && !pu)   m_ovf[i] = 1'b1;
                    else if (clr)    m_ovf[i] = 1'b0;
                    if (re && !po)   m_unf[i] = 1'b1;
                    else if (clr)    m_unf[i] = 1'b0;
                    m_val[i] = po;
                    if (po) m_out[i] = mq[i].pop_front();
                    if (pu) mq[i].push_back(din & msk[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [15:0] dout, input logic rv,
                            input logic full, input logic empty, input logic af,
                            input logic ae, input logic [5:0] cnt, input logic ovf,
                            input logic unf);
        int sz = mq[i].size();
        chk($sformatf("dut%0d fill_Count", i), 32'(cnt), sz);
        chk($sformatf("dut%0d sig_Full", i), 32'(full), 32'(sz == int'(dep[i])));
        chk($sformatf("dut%0d sig_Empty", i), 32'(empty), 32'(sz == 0));
        chk($sformatf("dut%0d sig_Almost_Full", i), 32'(af), 32'(sz >= int'(afth[i])));
        chk($sformatf("dut%0d sig_Almost_Empty", i), 32'(ae), 32'(sz <= int'(aeth[i])));
        chk($sformatf("dut%0d sig_Overflow", i), 32'(ovf), 32'(m_ovf[i]));
        chk($sformatf("dut%0d sig_Underflow", i), 32'(unf), 32'(m_unf[i]));
        if (fw[i]) begin
            chk($sformatf("dut%0d read_Valid", i), 32'(rv), 32'(sz != 0));
            if (sz != 0) chk($sformatf("dut%0d buffer_Output", i), 32'(dout), 32'(mq[i][0]));
        end else begin
            chk($sformatf("dut%0d read_Valid", i), 32'(rv), 32'(m_val[i]));
            chk($sformatf("dut%0d buffer_Output", i), 32'(dout), 32'(m_out[i]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!done) begin
                cmp_inst(0, {8'h00, d0_out}, d0_rv, d0_full, d0_empty, d0_af, d0_ae,
                         {2'b00, d0_cnt}, d0_ovf, d0_unf);
                cmp_inst(1, {8'h00, d1_out}, d1_rv, d1_full, d1_empty, d1_af, d1_ae,
                         {2'b00, d1_cnt}, d1_ovf, d1_unf);
                cmp_inst(2, d2_out, d2_rv, d2_full, d2_empty, d2_af, d2_ae,
                         d2_cnt, d2_ovf, d2_unf);
            end
        end
    end

    // Drives one cycle of inputs; returns 2 time units after the edge that consumed them.
    task automatic tick(input logic w, input logic r, input logic [15:0] d, input logic c);
        we = w; re = r; din = d; clr = c;
        @(posedge clock);
        #2;
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " empty"}, 32'(d0_empty), 1);
        chk({tag, " almost_empty"}, 32'(d0_ae), 1);
        chk({tag, " full"}, 32'(d0_full), 0);
        chk({tag, " almost_full"}, 32'(d0_af), 0);
        chk({tag, " count"}, 32'(d0_cnt), 0);
        chk({tag, " dout"}, 32'(d0_out), 0);
        chk({tag, " rvalid"}, 32'(d0_rv), 0);
        chk({tag, " ovf"}, 32'(d0_ovf), 0);
        chk({tag, " unf"}, 32'(d0_unf), 0);
        chk({tag, " fwft rvalid"}, 32'(d1_rv), 0);
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clock);
        #2;
        chk_reset_vals("reset");
        reset = 1'b1;

        // Fill dut0 with 0x11..0x88.
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 16'(k * 'h11), 1'b0);
            chk("fill count", 32'(d0_cnt), k);
            chk("fill almost_full", 32'(d0_af), 32'(k >= 6));
        end
        chk("fill full", 32'(d0_full), 1);

        tick(1'b1, 1'b0, 16'h0099, 1'b0);
        chk("overflow count", 32'(d0_cnt), 8);
        chk("overflow flag", 32'(d0_ovf), 1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("overflow sticky", 32'(d0_ovf), 1);

        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 1'b1, 16'h0000, 1'b0);
            chk("drain dout", 32'(d0_out), k * 'h11);
            chk("drain rvalid", 32'(d0_rv), 1);
        end
        chk("drain empty", 32'(d0_empty), 1);

        tick(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("underflow flag", 32'(d0_unf), 1);
        chk("underflow count", 32'(d0_cnt), 0);
        chk("underflow rvalid", 32'(d0_rv), 0);
        tick(1'b0, 1'b1, 16'h0000, 1'b1);
        chk("set beats clear", 32'(d0_unf), 1);
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("clear unf", 32'(d0_unf), 0);
        chk("clear ovf", 32'(d0_ovf), 0);

        // Simultaneous read/write at occupancy 4, wrapping the pointers.
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 16'(8'h21 + k), 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick(1'b1, 1'b1, 16'(8'h25 + j), 1'b0);
            chk("rw count", 32'(d0_cnt), 4);
            chk("rw order", 32'(d0_out), 8'h21 + j);
        end
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 16'(8'h31 + k), 1'b0);
        chk("rw refill full", 32'(d0_full), 1);
        tick(1'b1, 1'b1, 16'h0099, 1'b0);
        chk("rw full count", 32'(d0_cnt), 7);
        chk("rw full ovf", 32'(d0_ovf), 1);
        chk("rw full dout", 32'(d0_out), 8'h2b);
        chk("rw full wide count", 32'(d2_cnt), 8);
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 16'h0000, 1'b0);
        tick(1'b0, 1'b0, 16'h0000, 1'b1);

        // First-word-fall-through.
        tick(1'b1, 1'b0, 16'h00a5, 1'b0);
        chk("fwft dout", 32'(d1_out), 8'ha5);
        chk("fwft rvalid", 32'(d1_rv), 1);
        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("fwft hold", 32'(d1_out), 8'ha5);
        tick(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("fwft pop empty", 32'(d1_empty), 1);
        chk("fwft pop rvalid", 32'(d1_rv), 0);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 16'(8'h51 + k), 1'b0);
        tick(1'b1, 1'b1, 16'h0054, 1'b0);
        chk("pre-reset dout", 32'(d0_out), 8'h51);
        we = 1'b1; din = 16'h0055;
        #1 reset = 1'b0;
        #1 chk_reset_vals("mid reset");
        we = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;

        // Wide/deep instance thresholds.
        for (int k = 1; k <= 33; k++) begin
            tick(1'b1, 1'b0, 16'(16'h0100 + k), 1'b0);
            c = (k > 32) ? 32 : k;
            chk("wide count", 32'(d2_cnt), c);
            chk("wide almost_full", 32'(d2_af), 32'(c >= 30));
            chk("wide full", 32'(d2_full), 32'(c == 32));
            chk("wide almost_empty", 32'(d2_ae), 32'(c <= 1));
        end
        chk("wide overflow", 32'(d2_ovf), 1);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 1'b1, 16'h0000, 1'b0);
            chk("wide drain dout", 32'(d2_out), 16'h0100 + k);
            chk("wide drain almost_empty", 32'(d2_ae), 32'((32 - k) <= 1));
            chk("wide drain empty", 32'(d2_empty), 32'(k == 32));
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b1);

        @(negedge clock);
        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
